// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control unit: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects, write enables and ALU control, and counts retired instructions.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  output logic [2:0]  alucontrol,
  output logic [1:0]  alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  resultsrc,
  output logic [1:0]  immsrc,
  output logic        adrsrc,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        regwrite,
  output logic        memwrite,
  output logic        trap,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, JAL, BEQ, ALUWB, TRAP
  } state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;

  state_t state, next;
  aluop_t aluop;
  logic   irw, pcupdate, branch, rw, mw, retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= next;
      if (retire) instret <= instret + 32'd1;
    end
  end

  always_comb begin
    next = state;
    case (state)
      FETCH:  next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECR;
          OP_I:         next = EXECI;
          OP_JAL:       next = JAL;
          OP_BEQ:       next = BEQ;
          default:      next = TRAP;
        endcase
        if ((op == OP_R || op == OP_I) && (funct3 == 3'b011 || funct3 == 3'b101))
          next = TRAP;
      end
      MEMADR:   next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next = MEMWB;
      MEMWB:    next = FETCH;
      MEMWRITE: next = FETCH;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      JAL:      next = ALUWB;
      BEQ:      next = FETCH;
      ALUWB:    next = FETCH;
      TRAP:     next = TRAP;
      default:  next = TRAP;
    endcase
  end

  always_comb begin
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    adrsrc    = 1'b0;
    irw       = 1'b0;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    trap      = 1'b0;
    aluop     = ALU_ADD;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        irw       = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD: adrsrc = 1'b1;
      MEMWB: begin
        resultsrc = 2'b01;
        rw        = 1'b1;
        retire    = 1'b1;
      end
      MEMWRITE: begin
        adrsrc = 1'b1;
        mw     = 1'b1;
        retire = 1'b1;
      end
      EXECR: begin
        alusrca = 2'b10;
        aluop   = ALU_FUNCT;
      end
      EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALU_FUNCT;
      end
      JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      BEQ: begin
        alusrca = 2'b10;
        branch  = 1'b1;
        aluop   = ALU_SUB;
        retire  = 1'b1;
      end
      ALUWB: begin
        rw     = 1'b1;
        retire = 1'b1;
      end
      TRAP:    trap = 1'b1;
      default: trap = 1'b1;
    endcase
  end

  // Enables are gated by reset so the datapath stays quiet regardless of state.
  assign irwrite  = irw & ~reset;
  assign pcwrite  = (pcupdate | (branch & zero)) & ~reset;
  assign regwrite = rw & ~reset;
  assign memwrite = mw & ~reset;

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALU_ADD: alucontrol = 3'b000;
      ALU_SUB: alucontrol = 3'b001;
      ALU_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b001:  alucontrol = 3'b010;
          3'b010:  alucontrol = 3'b011;
          3'b100:  alucontrol = 3'b100;
          3'b110:  alucontrol = 3'b101;
          3'b111:  alucontrol = 3'b110;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

endmodule
